// File: rtl/word_narrow_tx_pkg.sv
// Shared definitions for the word narrowing serializer: size codes, FSM states
// and the size-to-last-byte-index mapping.
package word_narrow_tx_pkg;

    localparam logic [1:0] NARROW_BYTE = 2'b00;
    localparam logic [1:0] NARROW_HALF = 2'b01;
    localparam logic [1:0] NARROW_WORD = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Index of the final byte for a size code; 2'b11 behaves as a word.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            NARROW_BYTE: return 2'd0;
            NARROW_HALF: return 2'd1;
            default:     return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/word_narrow_tx_narrow_ovf_chk.sv
// Combinational check that the low bytes chosen by size, re-extended
// (signed or unsigned), reproduce the full input word.
module narrow_ovf_chk
    import word_narrow_tx_pkg::*;
#(
    parameter int DW = 32,
    parameter int BW = 8
) (
    input  logic [DW-1:0] data,
    input  logic [1:0]    size,
    input  logic          is_signed,
    output logic          ovf
);

    logic [DW-BW:0]   byte_top;
    logic [DW-2*BW:0] half_top;
    logic             unused_low;

    // Top slices include the sign bit of the narrowed value.
    assign byte_top   = data[DW-1:BW-1];
    assign half_top   = data[DW-1:2*BW-1];
    assign unused_low = ^data[BW-2:0];

    always_comb begin
        ovf = 1'b0;
        case (size)
            NARROW_BYTE: ovf = is_signed ? !((&byte_top) || !(|byte_top))
                                         : |byte_top[DW-BW:1];
            NARROW_HALF: ovf = is_signed ? !((&half_top) || !(|half_top))
                                         : |half_top[DW-2*BW:1];
            default:     ovf = 1'b0;
        endcase
    end

endmodule

// File: rtl/word_narrow_tx.sv
// Narrowing serializer: emits 1, 2 or 4 bytes of a word LSB first on a
// valid/ready byte stream. Optional overflow flag under NARROW_OVF_CHK_EN.
module word_narrow_tx
    import word_narrow_tx_pkg::*;
#(
    parameter int DW = 32,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_size,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_byte,
    output logic          out_last,
    output logic          busy
`ifdef NARROW_OVF_CHK_EN
    ,
    output logic          ovf
`endif
);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] shift;
    logic [1:0]    count;
    logic          rdy;
    logic          accept;
    logic          xfer;

    assign accept   = in_valid & rdy;
    assign xfer     = (state == S_SEND) & out_ready;
    assign in_ready = rdy;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_SEND;
            S_SEND: if (out_ready && count == 2'd0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == S_SEND);
        busy      = (state == S_SEND);
        out_last  = (state == S_SEND) && (count == 2'd0);
        out_byte  = shift[BW-1:0];
    end

    // in_ready is registered from the next state so it stays low during reset
    // and never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
            count <= '0;
            rdy   <= 1'b0;
        end else begin
            rdy <= (state_next == S_IDLE);
            if (accept) begin
                shift <= in_data;
                count <= last_index(in_size);
            end else if (xfer) begin
                if (count == 2'd0) begin
                    shift <= '0;
                end else begin
                    shift <= shift >> BW;
                    count <= count - 2'd1;
                end
            end
        end
    end

`ifdef NARROW_OVF_CHK_EN
    logic ovf_now;

    narrow_ovf_chk #(.DW(DW), .BW(BW)) u_ovf_chk (
        .data      (in_data),
        .size      (in_size),
        .is_signed (in_signed),
        .ovf       (ovf_now)
    );

    always_ff @(posedge clk) begin
        if (rst)         ovf <= 1'b0;
        else if (accept) ovf <= ovf_now;
    end
`else
    logic unused_signed;
    assign unused_signed = in_signed;
`endif

endmodule

// File: tb/tb_word_narrow_tx.sv
// Self-checking bench for word_narrow_tx; covers the ovf port when
// NARROW_OVF_CHK_EN is defined.
module tb_word_narrow_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        busy;
`ifdef NARROW_OVF_CHK_EN
    logic        ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    word_narrow_tx #(.DW(32), .BW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_size   (in_size),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy)
`ifdef NARROW_OVF_CHK_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Offers one word and collects the handshaken bytes. Called at a negedge.
    // rpat[k] is out_ready on the k-th cycle after acceptance.
    task automatic run_word(input logic [31:0] d, input logic [1:0] sz, input logic sg,
                            input logic [31:0] rpat, output logic [31:0] got,
                            output logic [3:0] lasts, output int n, output int unstable,
                            output int period, output bit tmo);
        int k;
        logic stalled;
        logic [7:0] held;
        got = '0; lasts = '0; n = 0; unstable = 0; period = 0; tmo = 1'b0;
        stalled = 1'b0; held = '0;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) begin
            tmo = 1'b1;
            return;
        end
        in_valid = 1'b1; in_data = d; in_size = sz; in_signed = sg; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_data = $urandom; in_size = 2'($urandom_range(0, 3));
        in_signed = 1'($urandom_range(0, 1));
        k = 0;
        tmo = 1'b1;
        while (k < 64) begin
            if (stalled && (out_valid !== 1'b1 || out_byte !== held)) unstable++;
            if (in_ready === 1'b1 && out_valid !== 1'b1) begin
                period = k + 1;
                tmo = 1'b0;
                break;
            end
            out_ready = (k < 32) ? rpat[k] : 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                if (n < 4) begin
                    got[8*n +: 8] = out_byte;
                    lasts[n] = out_last;
                end
                n++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held = out_byte;
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
    endtask

`ifdef NARROW_OVF_CHK_EN
    function automatic bit ref_ovf(input logic [31:0] d, input logic [1:0] sz, input bit sg);
        longint v;
        v = sg ? longint'($signed(d)) : longint'(d);
        case (sz)
            2'b00:   return sg ? (v < -128 || v > 127) : (v > 255);
            2'b01:   return sg ? (v < -32768 || v > 32767) : (v > 65535);
            default: return 1'b0;
        endcase
    endfunction
`endif

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h11223344; in_size = 2'b10;
        in_signed = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d in_ready=%b out_valid=%b expected 0/0", i, in_ready, out_valid);
            end
        end
        n_cmp++;
        if (out_byte !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs byte=%h last=%b busy=%b expected 00/0/0", out_byte, out_last, busy);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_word();
        logic [31:0] got; logic [3:0] lasts; int n, unst, per; bit tmo;
        run_word(32'h11223344, 2'b10, 1'b0, '1, got, lasts, n, unst, per, tmo);
        n_cmp++;
        if (tmo !== 1'b0 || n != 4 || got !== 32'h11223344 || lasts !== 4'b1000) begin
            n_fail++;
            $display("FAIL word tmo=%b n=%0d bytes=%h lasts=%b expected 0/4/11223344/1000", tmo, n, got, lasts);
        end
        n_cmp++;
        if (per != 5 || unst != 0) begin
            n_fail++;
            $display("FAIL word_timing period=%0d unstable=%0d expected 5/0", per, unst);
        end
`ifdef NARROW_OVF_CHK_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL word_ovf ovf=%b expected 0", ovf);
        end
`endif
    endtask

    task automatic test_byte_half();
        logic [31:0] got; logic [3:0] lasts; int n, unst, per; bit tmo;
        run_word(32'hAABBCCDD, 2'b00, 1'b0, '1, got, lasts, n, unst, per, tmo);
        n_cmp++;
        if (tmo !== 1'b0 || n != 1 || got[7:0] !== 8'hDD || lasts !== 4'b0001 || per != 2) begin
            n_fail++;
            $display("FAIL byte n=%0d byte=%h lasts=%b period=%0d expected 1/DD/0001/2", n, got[7:0], lasts, per);
        end
        run_word(32'h0000BEEF, 2'b01, 1'b0, '1, got, lasts, n, unst, per, tmo);
        n_cmp++;
        if (tmo !== 1'b0 || n != 2 || got[15:0] !== 16'hBEEF || lasts !== 4'b0010 || per != 3) begin
            n_fail++;
            $display("FAIL half n=%0d bytes=%h lasts=%b period=%0d expected 2/BEEF/0010/3", n, got[15:0], lasts, per);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got; logic [3:0] lasts; int n, unst, per; bit tmo;
        // ready sequence 1,0,0,1,1,0,1 then held high
        run_word(32'hCAFEF00D, 2'b10, 1'b0, 32'hFFFFFF59, got, lasts, n, unst, per, tmo);
        n_cmp++;
        if (tmo !== 1'b0 || n != 4 || got !== 32'hCAFEF00D || lasts !== 4'b1000) begin
            n_fail++;
            $display("FAIL backpressure n=%0d bytes=%h lasts=%b expected 4/CAFEF00D/1000", n, got, lasts);
        end
        n_cmp++;
        if (unst != 0 || per != 8) begin
            n_fail++;
            $display("FAIL backpressure_stall unstable=%0d period=%0d expected 0/8", unst, per);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got; logic [3:0] lasts; int n, unst, per; bit tmo;
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_size = 2'b10; in_signed = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_byte !== 8'hAD) begin
            n_fail++;
            $display("FAIL mid_progress valid=%b byte=%h expected 1/AD", out_valid, out_byte);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_byte !== 8'h00 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset valid=%b busy=%b byte=%h ready=%b expected 0/0/00/0",
                     out_valid, busy, out_byte, in_ready);
        end
        out_ready = 1'b0;
        run_word(32'h00000055, 2'b00, 1'b0, '1, got, lasts, n, unst, per, tmo);
        n_cmp++;
        if (tmo !== 1'b0 || n != 1 || got[7:0] !== 8'h55 || lasts !== 4'b0001) begin
            n_fail++;
            $display("FAIL after_reset n=%0d byte=%h lasts=%b expected 1/55/0001", n, got[7:0], lasts);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, d, rpat, mask; logic [3:0] lasts; logic [1:0] sz; logic sg;
        int n, unst, per, nb, ones, exp_per; bit tmo;
        for (int it = 0; it < 40; it++) begin
            d = $urandom;
            if (it % 4 == 0) d = (d[0]) ? 32'hFFFFFF00 | {24'h0, d[15:8]} : {24'h0, d[15:8]};
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            rpat = $urandom | 32'hFFFF0000;
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            mask = (nb == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nb)) - 32'h1);
            ones = 0; exp_per = 0;
            for (int k = 0; k < 32; k++) begin
                if (rpat[k]) ones++;
                if (ones == nb) begin
                    exp_per = k + 2;
                    break;
                end
            end
            run_word(d, sz, sg, rpat, got, lasts, n, unst, per, tmo);
            n_cmp++;
            if (tmo !== 1'b0 || n != nb || (got & mask) !== (d & mask)
                || lasts !== 4'(1 << (nb - 1)) || per != exp_per || unst != 0) begin
                n_fail++;
                $display("FAIL random it=%0d d=%h sz=%0d n=%0d bytes=%h lasts=%b period=%0d unstable=%0d expected n=%0d period=%0d",
                         it, d, sz, n, got & mask, lasts, per, unst, nb, exp_per);
            end
`ifdef NARROW_OVF_CHK_EN
            n_cmp++;
            if (ovf !== ref_ovf(d, sz, sg)) begin
                n_fail++;
                $display("FAIL random_ovf d=%h sz=%0d sg=%b ovf=%b expected %b", d, sz, sg, ovf, ref_ovf(d, sz, sg));
            end
`endif
        end
    endtask

`ifdef NARROW_OVF_CHK_EN
    task automatic test_ovf();
        logic [31:0] got; logic [3:0] lasts; int n, unst, per; bit tmo;
        logic [31:0] dv [4] = '{32'hFFFFFF80, 32'h00000180, 32'h00008000, 32'h80000000};
        logic [1:0]  sv [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic        gv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        ev [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_word(dv[i], sv[i], gv[i], '1, got, lasts, n, unst, per, tmo);
            n_cmp++;
            if (tmo !== 1'b0 || ovf !== ev[i]) begin
                n_fail++;
                $display("FAIL ovf_case%0d d=%h ovf=%b expected %b", i, dv[i], ovf, ev[i]);
            end
        end
    endtask
`endif

    initial begin
        in_valid = 1'b0; in_data = '0; in_size = '0; in_signed = 1'b0; out_ready = 1'b0; rst = 1'b1;
        test_reset();
        test_word();
        test_byte_half();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef NARROW_OVF_CHK_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/word_narrow_tx.md
Name: word_narrow_tx

Overview:
- Narrowing serializer; the inverse direction of the datapath immediate/data extender.
- Accepts a 32-bit CPU word plus a size code and emits 1, 2 or 4 bytes, LSB first, on a byte stream feeding the UART transmitter.
- Sits between the memory-mapped UART data register write path and the UART TX byte interface.
- Valid/ready handshake on both sides.

Parameters:
- DW, 32, input word width; must equal 4*BW.
- BW, 8, output lane width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  word offered.
- in_ready  out  1  block can accept a word.
- in_data  in  DW  word to narrow.
- in_size  in  2  NARROW_BYTE=2'b00 (1 byte), NARROW_HALF=2'b01 (2), NARROW_WORD=2'b10 (4); 2'b11 is treated as WORD.
- in_signed  in  1  interpretation for the overflow check; ignored without the macro.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  consumer takes the byte.
- out_byte  out  BW  current byte.
- out_last  out  1  current byte is the final byte of the word.
- busy  out  1  transaction in progress (state SEND).
- ovf  out  1  narrowing lost information; present only with the macro.

Behaviour:
- Reset: state IDLE; in_ready=0 while rst is high and 1 on the first cycle after; out_valid=0, out_byte=0, out_last=0, busy=0, ovf=0, shift register=0, count=0.
- State machine, two states:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: in_ready=0, out_valid=1, busy=1.
- Accept: when in_valid & in_ready at edge N, latch in_data into the shift register and set count = nbytes-1 (0, 1 or 3).
  - Go to SEND; out_valid=1 from cycle N+1.
  - out_byte = shift[BW-1:0]; out_last = (count==0).
- Byte transfer: when out_valid & out_ready at an edge:
  - count==0: go to IDLE.
  - Otherwise shift right by BW (zero fill) and decrement count.
- out_valid holds and out_byte stays stable while out_ready=0. There is no timeout.
- No back-to-back words: one IDLE cycle always follows the last byte. A 4-byte word with out_ready held high occupies 5 cycles, accept to next accept.
- in_data and in_size are ignored outside the accept cycle. Upper bytes beyond nbytes are never emitted.
- Reset mid-transaction: abort immediately. No partial byte is held; the next word starts clean.
- rst has priority over a simultaneous accept or byte transfer.
- All outputs are registered or decoded from state/registers only. No combinational path from in_* to out_*, nor from out_ready to in_ready.

Optional Feature:
- Macro NARROW_OVF_CHK_EN.
- Defined: ovf is computed at accept and held until the next accept or reset. ovf=1 when re-extending the emitted bytes would not reproduce in_data:
  - BYTE signed: in_data[31:7] not all equal.
  - BYTE unsigned: in_data[31:8] != 0.
  - HALF signed: in_data[31:15] not all equal.
  - HALF unsigned: in_data[31:16] != 0.
  - WORD: always 0.
- ovf is informational; bytes are emitted regardless.
- Undefined: the ovf port and its logic are absent, and in_signed is unconnected internally.

Decomposition:
- Shared definitions go in ctrl_encode_def.v:
  - NARROW_BYTE, NARROW_HALF, NARROW_WORD size codes (2 bits).
  - State codes S_IDLE, S_SEND.
- One sub-module is natural: narrow_ovf_chk.
  - Combinational; inputs data, size, signed; output ovf.
  - Instantiated only under NARROW_OVF_CHK_EN.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0 and out_valid=0 throughout; in_ready=1 on the first cycle after release.
- WORD: in_data=32'h11223344, size=2'b10, out_ready=1 -> bytes 44,33,22,11 on consecutive cycles, out_last only on 11. in_ready returns one cycle later; 5 cycles total.
- BYTE then HALF: size=00 with data 32'hAABBCCDD -> single DD with out_last=1. Then size=01 with data 32'h0000BEEF -> EF, BE.
- Backpressure: WORD 32'hCAFEF00D with out_ready toggling 1,0,0,1,1,0,1 -> out_byte stable while stalled. Sequence 0D,F0,FE,CA with no loss or duplication.
- Reset mid-word: assert rst after 2 of 4 bytes -> out_valid=0 next cycle. New word 32'h00000055 size=00 emits 55 only.
- NARROW_OVF_CHK_EN:
  - 32'hFFFFFF80 BYTE signed -> ovf=0.
  - 32'h00000180 BYTE unsigned -> ovf=1.
  - 32'h00008000 HALF signed -> ovf=1.
  - WORD with any data -> ovf=0.
